hazard_stall_flush_controller: RTL and testbench
================================================

// Module: hazard_stall_flush_controller
// PURPOSE
//  Pipeline hazard controller next to the execute-stage forwarding unit. Register writes reaching M/W are
//  forwarded; this block covers what forwarding cannot: load-use (F/D stall + E bubble), taken-branch redirect
//  (D/E flush) and data-memory wait (full pipe freeze). Watchdog FSM turns an unanswered data access into a
//  mem_fault pulse. Drives the enable/clear pins of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// PARAMETERS
//  MEM_TIMEOUT  255  consecutive wait cycles allowed before fault (>=2)
//  CNT_W        8    width of wait counter; 2**CNT_W > MEM_TIMEOUT
//  PERF_W       32   width of each performance counter
// PORTS
//  clk           in   1       single clock, rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  rs1_d,rs2_d   in   5       D-stage source registers
//  uses_rs1_d    in   1       D instr reads rs1;  uses_rs2_d  in 1  D instr reads rs2
//  rd_e          in   5       E-stage destination
//  memread_e     in   1       E instr is a load
//  pc_src_e      in   1       E-stage taken branch/jump (redirect)
//  dmem_req_m    in   1       M-stage data access in flight
//  dmem_ready_m  in   1       data memory completes access this cycle
//  stall_f,stall_d,stall_e,stall_m  out 1  hold stage register
//  flush_d,flush_e,flush_m,flush_w  out 1  clear stage register (bubble)
//  mem_fault     out  1       one-cycle timeout pulse
//  perf_lu_cnt,perf_mem_cnt,perf_flush_cnt  out PERF_W  perf counters
// BEHAVIOUR
//  - Outputs combinational from state + inputs. reset_n low: all outputs 0, state RUN, wait_cnt 0, perf 0.
//  - lu   = memread_e & rd_e!=0 & ((uses_rs1_d & rs1_d==rd_e) | (uses_rs2_d & rs2_d==rd_e)).
//  - wait = dmem_req_m & ~dmem_ready_m.
//  - FSM RUN/WAIT/FAULT, priority FAULT > freeze > redirect > lu:
//    RUN:   wait -> freeze, next WAIT, wait_cnt<=1. Else pc_src_e -> flush_d=flush_e=1, stall_f=stall_d=0 (lu ignored).
//           Else lu -> stall_f=stall_d=1, flush_e=1. Else all 0.
//    WAIT:  freeze while wait. ready -> outputs as RUN (freeze drops same cycle), next RUN, wait_cnt<=0.
//           wait & wait_cnt==MEM_TIMEOUT -> next FAULT; else wait_cnt++.
//    FAULT: one cycle: mem_fault=1, flush_d=flush_e=flush_m=1, stall_f=1; next RUN, wait_cnt<=0.
//  - Freeze = stall_f=stall_d=stall_e=stall_m=1, flush_w=1; lu/redirect masked, re-evaluated after release.
//  - Watchdog limit: fault after MEM_TIMEOUT+1 wait cycles (incl. the RUN detection cycle). wait_cnt never wraps.
//  - dmem_req_m falling in WAIT without ready: treated as ready (exit to RUN), no fault.
//  - flush_* and stall_* for the same stage are never both 1.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: wrapping counters: perf_lu_cnt +1 per lu-stall cycle, perf_mem_cnt +1 per
//   freeze cycle, perf_flush_cnt +1 per redirect cycle; all 0 on reset.
//  Undefined: counter logic removed, perf_* ports tied to 0; rest unchanged.
// TESTING
//  lw x5 in E, D reads x5 (uses_rs1_d=1) -> one cycle stall_f=stall_d=flush_e=1; rd_e=0 case -> no stall.
//  lu and pc_src_e same cycle -> flush_d=flush_e=1, stall_f=stall_d=0.
//  dmem_req_m=1, ready low 3 cycles then high -> 3 freeze cycles, release on ready cycle, FSM RUN.
//  MEM_TIMEOUT=4, ready never -> freeze 5 cycles, then mem_fault 1 cycle with flush_d/e/m, back to RUN.
//  reset_n low mid-WAIT -> all outputs 0 immediately; after release RUN, wait_cnt=0, fresh timeout.
//  HAZARD_PERF_CNT_EN: 2 lu + 3 freeze + 1 redirect -> perf_lu_cnt=2, perf_mem_cnt=3, perf_flush_cnt=1.

Source files
------------

// File: rtl/hazard_stall_flush_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_flush_controller
//
// Purpose
//   This is the pipeline hazard controller that sits next to the execute-stage
//   forwarding unit. It handles the hazards that forwarding cannot resolve:
//     - load-use:  stall F/D and insert a bubble into E
//     - redirect:  flush D/E when a branch or jump is taken in E
//     - mem wait:  freeze the whole pipe while a data access is pending
//   A watchdog turns an unanswered data access into a one-cycle mem_fault pulse.
//   The outputs drive the enable/clear pins of the IF/ID, ID/EX, EX/MEM and
//   MEM/WB pipeline registers.
//
// Configuration
//   HAZARD_PERF_CNT_EN  When defined, the three wrapping performance counters
//                       are built. When undefined, the perf_* ports are tied
//                       to 0.
//
// Parameters
//   MEM_TIMEOUT  Consecutive wait cycles allowed before a fault. Must be >= 2.
//   CNT_W        Width of the wait counter. Requires 2**CNT_W > MEM_TIMEOUT.
//   PERF_W       Width of each performance counter.
//
// Ports
//   clk, reset_n                      Clock (rising edge); async active-low reset.
//   rs1_d, rs2_d, uses_rs1_d/rs2_d    D-stage source registers and their use flags.
//   rd_e, memread_e                   E-stage destination register; E is a load.
//   pc_src_e                          E-stage taken branch/jump.
//   dmem_req_m, dmem_ready_m          M-stage access in flight; access completes.
//   stall_f/d/e/m, flush_d/e/m/w      Stage register hold / clear.
//   mem_fault                         One-cycle watchdog timeout pulse.
//   perf_lu_cnt, perf_mem_cnt,
//   perf_flush_cnt                    Load-use, freeze and redirect cycle counts.
// -----------------------------------------------------------------------------
module hazard_stall_flush_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic              uses_rs1_d,
  input  logic              uses_rs2_d,
  input  logic [4:0]        rd_e,
  input  logic              memread_e,
  input  logic              pc_src_e,
  input  logic              dmem_req_m,
  input  logic              dmem_ready_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              mem_fault,
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_mem_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic lu_hit;
  logic mem_wait;
  logic do_freeze;
  logic do_redirect;
  logic do_lu;
  logic do_fault;

  // Hazard detection. Register x0 never creates a dependency.
  assign lu_hit = memread_e && (rd_e != 5'd0) &&
                  ((uses_rs1_d && (rs1_d == rd_e)) ||
                   (uses_rs2_d && (rs2_d == rd_e)));

  assign mem_wait = dmem_req_m && !dmem_ready_m;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic and action selection.
  // Priority order: fault, then freeze, then redirect, then load-use.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    do_freeze    = 1'b0;
    do_redirect  = 1'b0;
    do_lu        = 1'b0;
    do_fault     = 1'b0;
    unique case (state)
      S_RUN: begin
        if (mem_wait) begin
          // The detection cycle counts as the first wait cycle.
          do_freeze    = 1'b1;
          state_nxt    = S_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end else begin
          do_redirect = pc_src_e;
          do_lu       = !pc_src_e && lu_hit;
        end
      end
      S_WAIT: begin
        if (mem_wait) begin
          do_freeze = 1'b1;
          if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            state_nxt = S_FAULT;
          end else begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
        end else begin
          // Either ready arrived or the request was withdrawn. The freeze
          // drops in this same cycle, and any hazards that were masked
          // during the freeze are evaluated again here.
          do_redirect  = pc_src_e;
          do_lu        = !pc_src_e && lu_hit;
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end
      end
      S_FAULT: begin
        do_fault     = 1'b1;
        state_nxt    = S_RUN;
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = S_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode. All outputs are forced low while reset is asserted.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    flush_w   = 1'b0;
    mem_fault = 1'b0;
    if (reset_n) begin
      if (do_fault) begin
        mem_fault = 1'b1;
        stall_f   = 1'b1;
        flush_d   = 1'b1;
        flush_e   = 1'b1;
        flush_m   = 1'b1;
      end else if (do_freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (do_redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (do_lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters. They wrap on overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_lu_cnt    <= '0;
      perf_mem_cnt   <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (do_lu)       perf_lu_cnt    <= perf_lu_cnt + PERF_W'(1);
      if (do_freeze)   perf_mem_cnt   <= perf_mem_cnt + PERF_W'(1);
      if (do_redirect) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`else
  assign perf_lu_cnt    = '0;
  assign perf_mem_cnt   = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_flush_controller.sv
module tb_hazard_stall_flush_controller;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int PERF_W      = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic uses_rs1_d, uses_rs2_d, memread_e, pc_src_e, dmem_req_m, dmem_ready_m;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, mem_fault;
  logic [PERF_W-1:0] perf_lu_cnt, perf_mem_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  hazard_stall_flush_controller #(
    .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
    .rd_e(rd_e), .memread_e(memread_e), .pc_src_e(pc_src_e),
    .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .mem_fault(mem_fault),
    .perf_lu_cnt(perf_lu_cnt), .perf_mem_cnt(perf_mem_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: the length of the current run of wait cycles,
  // a pending-fault flag, and cycle tallies for each hazard category.
  int          m_wlen  = 0;
  bit          m_fault = 0;
  logic [PERF_W-1:0] m_lu = '0, m_mem = '0, m_fl = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic pc,
                       input logic req, input logic rdy);
    rs1_d = r1; rs2_d = r2; uses_rs1_d = u1; uses_rs2_d = u2;
    rd_e = rd; memread_e = mr; pc_src_e = pc; dmem_req_m = req; dmem_ready_m = rdy;
  endtask

  function automatic logic [8:0] outs();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, mem_fault};
  endfunction

  // Call this at a negedge, after the inputs are set. It checks one cycle
  // against the model and then advances to the next negedge.
  task automatic cyc(input string tag);
    logic lu, wt;
    logic [8:0] e;
    int cat; // 0 none, 1 lu, 2 freeze, 3 redirect, 4 fault
    #1;
    lu = memread_e && rd_e != 0 &&
         ((uses_rs1_d && rs1_d == rd_e) || (uses_rs2_d && rs2_d == rd_e));
    wt = dmem_req_m && !dmem_ready_m;
    if (m_fault)       cat = 4;
    else if (wt)       cat = 2;
    else if (pc_src_e) cat = 3;
    else if (lu)       cat = 1;
    else               cat = 0;
    case (cat)
      1: e = 9'b1100_0100_0;
      2: e = 9'b1111_0001_0;
      3: e = 9'b0000_1100_0;
      4: e = 9'b1000_1110_1;
      default: e = 9'b0;
    endcase
    chk({tag, ".outs"}, 64'(outs()), 64'(e));
    chk({tag, ".perf_lu"}, 64'(perf_lu_cnt), PERF_ON ? 64'(m_lu) : 64'd0);
    chk({tag, ".perf_mem"}, 64'(perf_mem_cnt), PERF_ON ? 64'(m_mem) : 64'd0);
    chk({tag, ".perf_fl"}, 64'(perf_flush_cnt), PERF_ON ? 64'(m_fl) : 64'd0);
    @(posedge clk);
    if (cat == 1) m_lu++;
    if (cat == 2) m_mem++;
    if (cat == 3) m_fl++;
    if (m_fault) begin
      m_fault = 0;
      m_wlen  = 0;
    end else if (wt) begin
      m_wlen++;
      if (m_wlen == MEM_TIMEOUT + 1) begin
        m_fault = 1;
        m_wlen  = 0;
      end
    end else begin
      m_wlen = 0;
    end
    @(negedge clk);
  endtask

  // Asserts reset at a negedge while a freeze is being requested and checks
  // that the outputs clear immediately. Releases reset two cycles later.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, ".outs0"}, 64'(outs()), 64'd0);
    chk({tag, ".perf0"}, 64'({perf_lu_cnt, perf_mem_cnt, perf_flush_cnt}), 64'd0);
    m_wlen = 0; m_fault = 0; m_lu = '0; m_mem = '0; m_fl = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    reset_n = 1'b1;
    @(negedge clk);
    do_reset("rst");

    // Load-use on x5, then the same pattern with rd_e=0.
    drive(5, 7, 1, 0, 5, 1, 0, 0, 0); cyc("lu_x5");
    drive(0, 7, 1, 0, 0, 1, 0, 0, 0); cyc("lu_x0");
    drive(3, 9, 0, 1, 9, 1, 0, 0, 0); cyc("lu_rs2");
    // Load-use together with a redirect: the redirect wins.
    drive(5, 7, 1, 0, 5, 1, 1, 0, 0); cyc("lu_redir");

    // Three wait cycles, then ready.
    for (int i = 0; i < 3; i++) begin drive(5, 0, 1, 0, 5, 1, 1, 1, 0); cyc("wait3"); end
    drive(5, 0, 1, 0, 5, 1, 0, 1, 1); cyc("wait3_rel");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("idle");

    // Ready never arrives: 5 freeze cycles, then the fault, then RUN.
    for (int i = 0; i < 7; i++) begin drive(1, 2, 1, 1, 1, 1, 0, 1, 0); cyc("tmo"); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("tmo_idle");

    // Request withdrawn during WAIT without ready: treated as a completion.
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("drop"); end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("drop_rel");

    // Reset in the middle of WAIT, then a fresh full timeout.
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("midw"); end
    do_reset("rst_midw");
    for (int i = 0; i < 7; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("fresh_tmo"); end

    // Performance counters: 2 load-use, 3 freeze, 1 redirect.
    @(negedge clk);
    do_reset("rst_perf");
    for (int i = 0; i < 2; i++) begin drive(4, 0, 1, 0, 4, 1, 0, 0, 0); cyc("p_lu"); end
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("p_mem"); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); cyc("p_rel");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("p_fl");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("perf_lu_tot",  64'(perf_lu_cnt),    PERF_ON ? 64'd2 : 64'd0);
    chk("perf_mem_tot", 64'(perf_mem_cnt),   PERF_ON ? 64'd3 : 64'd0);
    chk("perf_fl_tot",  64'(perf_flush_cnt), PERF_ON ? 64'd1 : 64'd0);
    @(negedge clk);

    // Randomized traffic, with occasional long periods where the memory is stuck.
    begin
      int stuck = 0;
      for (int n = 0; n < 3000; n++) begin
        logic req, rdy;
        if (stuck == 0 && $urandom_range(0, 49) == 0) stuck = $urandom_range(3, 9);
        if (stuck > 0) begin
          req = 1'b1; rdy = 1'b0; stuck--;
        end else begin
          req = ($urandom_range(0, 3) == 0);
          rdy = ($urandom_range(0, 2) == 0);
        end
        drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
              1'($urandom), ($urandom_range(0, 5) == 0), req, rdy);
        if ($urandom_range(0, 999) == 0) begin
          do_reset("rnd_rst");
        end else begin
          cyc("rnd");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
